// File: rtl/seq_subtractor_5_bit.sv
// -----------------------------------------------------------------------------
// seq_subtractor_5_bit
//   Bit-serial subtractor for the calculator datapath. It computes
//   Diff = A - B - Bin one bit per clock, least significant bit first. A
//   start/busy/done handshake connects it to the calculator control FSM.
//
//   Latency: the start edge is followed by WIDTH RUN edges. done is high in
//   the cycle after the last RUN edge, which is WIDTH clocks after the start
//   edge. A start that arrives in the DONE cycle is accepted (back-to-back).
//   A start that arrives while busy is ignored.
//
// Parameters
//   WIDTH  operand/result width and iteration count (default 5)
//
// Ports
//   clk    in   rising-edge system clock
//   rst    in   asynchronous active-high reset
//   start  in   request pulse; A/B/Bin are sampled on the same edge
//   A      in   minuend  [WIDTH-1:0]
//   B      in   subtrahend [WIDTH-1:0]
//   Bin    in   borrow in
//   Diff   out  registered result, held until the next completion
//   Bout   out  registered borrow out of the MSB
//   busy   out  high while an operation is in progress
//   done   out  one-cycle completion strobe
//   Ovf    out  signed overflow of A - B - Bin (present only with SUB_OVF_EN)
//
// Build option
//   SUB_OVF_EN  when defined, adds the Ovf output and its borrow-into-MSB flop
// -----------------------------------------------------------------------------
module seq_subtractor_5_bit #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  // The counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
`ifdef SUB_OVF_EN
  logic             r_br_msb;
`endif

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_d_shifted;

  // One full-subtractor slice on the current LSBs plus the shifted result.
  always_comb begin
    w_d         = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    w_br_next   = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    w_last      = (r_cnt == CNT_LAST);
    w_d_shifted = {w_d, r_d_sh[WIDTH-1:1]};
  end

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= CNT_ZERO;
      Diff     <= '0;
      Bout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SUB_OVF_EN
      r_br_msb <= 1'b0;
      Ovf      <= 1'b0;
`endif
    end else begin
      // done is a strobe: it is only raised on the final RUN edge below.
      done <= 1'b0;
      case (r_state)
        // IDLE and DONE both accept a new request; DONE just lasts one cycle.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_br    <= Bin;
            r_d_sh  <= '0;
            r_cnt   <= CNT_ZERO;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_d_sh <= w_d_shifted;
          r_br   <= w_br_next;
`ifdef SUB_OVF_EN
          // The borrow produced by bit WIDTH-2 is the borrow into the MSB.
          if (r_cnt == CNT_W'(WIDTH - 2)) begin
            r_br_msb <= w_br_next;
          end else begin
            r_br_msb <= r_br_msb;
          end
`endif
          if (w_last) begin
            // Counter holds at WIDTH-1 rather than wrapping.
            Diff    <= w_d_shifted;
            Bout    <= w_br_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_DONE;
`ifdef SUB_OVF_EN
            Ovf     <= r_br_msb ^ w_br_next;
`endif
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor_5_bit.sv
// -----------------------------------------------------------------------------
// tb_seq_subtractor_5_bit
//   Directed bench for seq_subtractor_5_bit with hand-computed expectations.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Define SUB_OVF_EN to also exercise the Ovf output.
// -----------------------------------------------------------------------------
module tb_seq_subtractor_5_bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] a_s;
  logic [4:0] b_s;
  logic       bin_s;
  logic [4:0] diff_s;
  logic       bout_s;
  logic       busy_s;
  logic       done_s;
`ifdef SUB_OVF_EN
  logic       ovf_s;
`endif

  int         test_cnt;
  int         fail_cnt;
  logic [4:0] prev_diff;
  logic       prev_bout;

  seq_subtractor_5_bit #(.WIDTH(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_s),
    .B     (b_s),
    .Bin   (bin_s),
    .Diff  (diff_s),
    .Bout  (bout_s),
    .busy  (busy_s),
    .done  (done_s)
`ifdef SUB_OVF_EN
    ,
    .Ovf   (ovf_s)
`endif
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a start pulse at the current falling edge; returns at the falling
  // edge after the start edge with operands scrambled to prove they were latched.
  task automatic launch(input logic [4:0] a, input logic [4:0] b, input logic bin);
    a_s   = a;
    b_s   = b;
    bin_s = bin;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_s   = ~a;
    b_s   = ~b;
    bin_s = ~bin;
  endtask

  // Walk the five RUN cycles and check the DONE cycle. With poke set, a
  // conflicting start (1 - 1) is raised while busy and must be ignored.
  task automatic expect_result(input string tag, input logic [4:0] exp_diff,
                               input logic exp_bout, input logic exp_ovf,
                               input logic poke);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_busy"}, {31'd0, busy_s}, 32'd1);
      chk({tag, "_done_low"}, {31'd0, done_s}, 32'd0);
      chk({tag, "_diff_hold"}, {27'd0, diff_s}, {27'd0, prev_diff});
      chk({tag, "_bout_hold"}, {31'd0, bout_s}, {31'd0, prev_bout});
      if (poke && i == 1) begin
        a_s   = 5'd1;
        b_s   = 5'd1;
        bin_s = 1'b0;
        start = 1'b1;
      end else if (poke && i == 2) begin
        start = 1'b0;
      end else begin
        start = start;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_done"}, {31'd0, done_s}, 32'd1);
    chk({tag, "_busy_low"}, {31'd0, busy_s}, 32'd0);
    chk({tag, "_diff"}, {27'd0, diff_s}, {27'd0, exp_diff});
    chk({tag, "_bout"}, {31'd0, bout_s}, {31'd0, exp_bout});
`ifdef SUB_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf_s}, {31'd0, exp_ovf});
`endif
    $display("[TB] step %s complete (model ovf %0d)", tag, exp_ovf);
    prev_diff = exp_diff;
    prev_bout = exp_bout;
  endtask

  // One cycle after DONE with no start: strobe gone, back in IDLE, result held.
  task automatic idle_check(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_strobe_once"}, {31'd0, done_s}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy_s}, 32'd0);
    chk({tag, "_idle_diff"}, {27'd0, diff_s}, {27'd0, prev_diff});
  endtask

  initial begin
    test_cnt  = 0;
    fail_cnt  = 0;
    prev_diff = 5'd0;
    prev_bout = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    a_s       = 5'd0;
    b_s       = 5'd0;
    bin_s     = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_diff", {27'd0, diff_s}, 32'd0);
    chk("rst_bout", {31'd0, bout_s}, 32'd0);
    chk("rst_busy", {31'd0, busy_s}, 32'd0);
    chk("rst_done", {31'd0, done_s}, 32'd0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf_s}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 9 - 3 = 6.
    launch(5'd9, 5'd3, 1'b0);
    expect_result("sub_9_3", 5'd6, 1'b0, 1'b0, 1'b0);
    idle_check("sub_9_3");

    // 3 - 9 = -6 -> 26 with borrow; a start while busy is ignored.
    launch(5'd3, 5'd9, 1'b0);
    expect_result("sub_3_9", 5'd26, 1'b1, 1'b0, 1'b1);
    idle_check("sub_3_9");

    // 0 - 0 - 1 = 31 with borrow.
    launch(5'd0, 5'd0, 1'b1);
    expect_result("sub_0_0_b", 5'd31, 1'b1, 1'b0, 1'b0);
    idle_check("sub_0_0_b");

    // 10 - 4 - 1 = 5.
    launch(5'd10, 5'd4, 1'b1);
    expect_result("sub_10_4_b", 5'd5, 1'b0, 1'b0, 1'b0);
    idle_check("sub_10_4_b");

    // 31 - 31 = 0, then 20 - 5 = 15 restarted in the DONE cycle
    // (signed -12 - 5 = -17 overflows).
    launch(5'd31, 5'd31, 1'b0);
    expect_result("sub_31_31", 5'd0, 1'b0, 1'b0, 1'b0);
    launch(5'd20, 5'd5, 1'b0);
    expect_result("b2b_20_5", 5'd15, 1'b0, 1'b1, 1'b0);
    idle_check("b2b_20_5");

    // Reset two clocks into an operation.
    launch(5'd7, 5'd2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy_s}, 32'd0);
    chk("midrst_done", {31'd0, done_s}, 32'd0);
    chk("midrst_diff", {27'd0, diff_s}, 32'd0);
    chk("midrst_bout", {31'd0, bout_s}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    prev_diff = 5'd0;
    prev_bout = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done_s}, 32'd0);
    end
    launch(5'd9, 5'd3, 1'b0);
    expect_result("after_rst", 5'd6, 1'b0, 1'b0, 1'b0);
    idle_check("after_rst");

    // Signed overflow cases.
    launch(5'd16, 5'd1, 1'b0);
    expect_result("ovf_16_1", 5'd15, 1'b0, 1'b1, 1'b0);
    idle_check("ovf_16_1");
    launch(5'd15, 5'd31, 1'b0);
    expect_result("ovf_15_31", 5'd16, 1'b1, 1'b1, 1'b0);
    idle_check("ovf_15_31");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
